bcd_entry_display: RTL and testbench
====================================

BCD_ENTRY_DISPLAY -- requirements
Module: bcd_entry_display

Interface
REQ-001 Parameter N_DIGITS, default 4: number of BCD digits held and displayed (range 1..8).
REQ-002 Parameter BIN_W, default 14: binary result width; SHALL satisfy 2^BIN_W > 10^N_DIGITS - 1.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port key_valid, input, 1: high while a keypad key is held.
REQ-006 Port key_code, input, 4: code of the held key; 0-9 digit, 0xA clear, 0xB backspace, 0xC enter, 0xD-0xF ignored.
REQ-007 Port digits_bcd, output, 4*N_DIGITS: entered digits, digit 0 (least significant) in bits [3:0].
REQ-008 Port digit_count, output, 4: number of digits entered (0..N_DIGITS).
REQ-009 Port segs, output, 7*N_DIGITS: active-low segments, bits a..g per digit, digit 0 in bits [6:0].
REQ-010 Port overflow, output, 1: sticky; a digit was rejected because the buffer was full.
REQ-011 Port value, output, BIN_W: binary value of the last entered number.
REQ-012 Port value_valid, output, 1: one-cycle pulse when value updates.
REQ-013 Port busy, output, 1: high while a conversion runs.

Function
REQ-014 A key event SHALL be the rising edge of key_valid (registered previous sample); a held key SHALL generate exactly one event.
REQ-015 key_code SHALL be sampled in the same cycle as the key_valid rising edge.
REQ-016 On a digit event with digit_count < N_DIGITS: digits SHALL shift up one position, the new digit SHALL enter digit 0, and digit_count SHALL increment, all visible on the next cycle.
REQ-017 On a digit event with digit_count = N_DIGITS: digits SHALL be unchanged and overflow SHALL set.
REQ-018 Clear SHALL zero all digits, zero digit_count and clear overflow; value SHALL be unchanged.
REQ-019 Backspace SHALL shift digits down one position, insert 0 in the top position, and decrement digit_count; at digit_count = 0 it SHALL have no effect.
REQ-020 Enter SHALL start a conversion in FSM states IDLE -> CONV -> DONE -> IDLE.
REQ-021 In CONV: acc starts at 0; each cycle, acc = acc*10 + next digit, taking digits most significant first over exactly N_DIGITS cycles. busy SHALL be high throughout CONV.
REQ-022 In DONE: value <= acc and value_valid SHALL pulse for one cycle. The value SHALL appear N_DIGITS+1 cycles after the enter event cycle.
REQ-023 Key events whose rising edge falls while busy is high SHALL be ignored entirely, including clear.
REQ-024 Enter with digit_count = 0 SHALL convert and produce value = 0.
REQ-025 Entry SHALL NOT change digits or digit_count.
REQ-026 segs SHALL be combinational from digits_bcd, using the 0-9 glyphs.

Reset
REQ-027 rst SHALL force the following, overriding any simultaneous key event: digits 0, digit_count 0, overflow 0, value 0, value_valid 0, busy 0, FSM IDLE, key_valid history 0.
REQ-028 rst during CONV SHALL abort the conversion with no value_valid pulse.
REQ-029 A key held through rst release SHALL NOT produce an event until it is released and pressed again.

Configuration
REQ-030 With BCD_ENTRY_LZB_EN defined, leading zeros above position digit_count-1 SHALL be blanked (segs all 1). With digit_count = 0, only digit 0 SHALL show "0".
REQ-031 Without BCD_ENTRY_LZB_EN, every digit SHALL always be displayed.

Structure
REQ-032 Package bcd_entry_pkg SHALL hold the key code constants (KEY_CLEAR, KEY_BKSP, KEY_ENTER), the FSM state typedef, and the segment glyph constants.
REQ-033 Sub-module seg7_decode (4-bit BCD in, blank in, 7-bit active-low out) SHALL be instantiated once per digit.

Verification
REQ-034 Press 1,2,3,4 then enter -> digits_bcd 0x1234, digit_count 4, value 1234 with value_valid 5 cycles after the enter edge.
REQ-035 Press 9 five times with N_DIGITS 4 -> digits 0x9999, overflow 1; then clear -> digits 0, count 0, overflow 0.
REQ-036 Press 5,6 then backspace -> digits 0x0005, count 1; backspace twice more -> count 0, no underflow.
REQ-037 Hold key 7 for 20 cycles -> exactly one digit entered.
REQ-038 Enter, press 3 during busy, assert rst in the 2nd CONV cycle -> no value_valid, all outputs reset.
REQ-039 With BCD_ENTRY_LZB_EN, digits 0x0042 -> segs of digits 3 and 2 all ones, digits 1 and 0 showing 4 and 2; without the macro -> "0042".

Source files
------------

// File: rtl/bcd_entry_pkg.sv
// Shared constants for the BCD keypad entry/display block: key codes,
// conversion FSM states and active-low 7-segment glyphs (bit 0 = a ... bit 6 = g).
package bcd_entry_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_entry_display_seg7.sv
// One-digit BCD to active-low 7-segment decoder with a blanking input.
module seg7_decode
  import bcd_entry_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_entry_display.sv
// Keypad BCD entry buffer with 7-segment display and serial BCD->binary conversion.
// Define BCD_ENTRY_LZB_EN to blank leading zeros above the entered digits.
module bcd_entry_display
  import bcd_entry_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic [4*N_DIGITS-1:0] digits_bcd,
  output logic [3:0]            digit_count,
  output logic [7*N_DIGITS-1:0] segs,
  output logic                  overflow,
  output logic [BIN_W-1:0]      value,
  output logic                  value_valid,
  output logic                  busy
);

  state_t state_q, state_d;

  logic                      key_prev_q, key_prev_d;
  logic                      armed_q, armed_d;
  logic [N_DIGITS-1:0][3:0]  digits_q, digits_d;
  logic [3:0]                count_q, count_d;
  logic                      ovf_q, ovf_d;
  logic [BIN_W-1:0]          value_q, value_d;
  logic [BIN_W-1:0]          acc_q, acc_d;
  logic [3:0]                step_q, step_d;

  logic             key_evt, accept, start, last_step;
  logic [3:0]       conv_digit;
  logic [BIN_W-1:0] acc_next;

  // armed drops when a key is held across reset, so that press never fires
  assign key_evt   = key_valid & ~key_prev_q & armed_q;
  assign accept    = key_evt & ~busy;
  assign start     = accept & (key_code == KEY_ENTER);
  assign last_step = (step_q == 4'(N_DIGITS - 1));

  always_comb begin
    conv_digit = '0;
    for (int i = 0; i < N_DIGITS; i++)
      if (step_q == 4'(N_DIGITS - 1 - i)) conv_digit = digits_q[i];
  end

  assign acc_next = acc_q * BIN_W'(10) + BIN_W'(conv_digit);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CONV;
      ST_CONV: if (last_step) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_CONV : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == ST_CONV);
    value_valid = (state_q == ST_DONE);
  end

  always_comb begin
    key_prev_d = key_valid;
    armed_d    = armed_q | ~key_valid;
    digits_d   = digits_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    if (accept) begin
      if (key_code <= 4'd9) begin
        if (count_q < 4'(N_DIGITS)) begin
          for (int i = N_DIGITS - 1; i > 0; i--) digits_d[i] = digits_q[i-1];
          digits_d[0] = key_code;
          count_d     = count_q + 4'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (key_code == KEY_CLEAR) begin
        digits_d = '0;
        count_d  = '0;
        ovf_d    = 1'b0;
      end else if (key_code == KEY_BKSP && count_q != 4'd0) begin
        for (int i = 0; i < N_DIGITS - 1; i++) digits_d[i] = digits_q[i+1];
        digits_d[N_DIGITS-1] = 4'd0;
        count_d = count_q - 4'd1;
      end
    end
  end

  // value is loaded on the final CONV edge so it is visible together with DONE
  always_comb begin
    acc_d   = acc_q;
    step_d  = step_q;
    value_d = value_q;
    if (state_q == ST_CONV) begin
      acc_d  = acc_next;
      step_d = step_q + 4'd1;
      if (last_step) value_d = acc_next;
    end else if (start) begin
      acc_d  = '0;
      step_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_prev_q <= 1'b0;
      armed_q    <= ~key_valid;
      digits_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      value_q    <= '0;
      acc_q      <= '0;
      step_q     <= '0;
    end else begin
      key_prev_q <= key_prev_d;
      armed_q    <= armed_d;
      digits_q   <= digits_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      value_q    <= value_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
    end
  end

  assign digits_bcd  = digits_q;
  assign digit_count = count_q;
  assign overflow    = ovf_q;
  assign value       = value_q;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dig
    logic blank;
`ifdef BCD_ENTRY_LZB_EN
    assign blank = (g != 0) && (4'(g) >= count_q);
`else
    assign blank = 1'b0;
`endif
    seg7_decode u_seg (
      .bcd   (digits_q[g]),
      .blank (blank),
      .seg   (segs[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_bcd_entry_display.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized keypad traffic checked every cycle against a behavioural model.
module tb_bcd_entry_display;

  localparam int N  = 4;
  localparam int BW = 14;
`ifdef BCD_ENTRY_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, kv;
  logic [3:0]      kc;
  logic [4*N-1:0]  digits_bcd;
  logic [3:0]      digit_count;
  logic [7*N-1:0]  segs;
  logic            overflow, value_valid, busy;
  logic [BW-1:0]   value;

  bcd_entry_display #(.N_DIGITS(N), .BIN_W(BW)) dut (
    .clk(clk), .rst(rst), .key_valid(kv), .key_code(kc),
    .digits_bcd(digits_bcd), .digit_count(digit_count), .segs(segs),
    .overflow(overflow), .value(value), .value_valid(value_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // glyphs as lists of lit segments; a lit segment drives its bit low
  string GL [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                     "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  function automatic logic [6:0] glyph(input int d);
    logic [6:0] g;
    string s;
    g = 7'h7F;
    s = GL[d];
    for (int i = 0; i < s.len(); i++) g[int'(s[i]) - 97] = 1'b0;
    return g;
  endfunction

  // behavioural model
  int m_dig [N];
  int m_cnt, m_val, m_timer, m_conv;
  bit m_ovf, m_prev, m_armed;

  always @(posedge clk) begin
    bit ev, bsy;
    if (rst) begin
      for (int i = 0; i < N; i++) m_dig[i] = 0;
      m_cnt = 0; m_val = 0; m_timer = 0; m_conv = 0; m_ovf = 0;
      m_prev = 0; m_armed = !kv;
    end else begin
      ev = kv && !m_prev && m_armed;
      m_armed = m_armed || !kv;
      m_prev = kv;
      bsy = (m_timer >= 2);
      if (m_timer > 0) begin
        m_timer--;
        if (m_timer == 1) m_val = m_conv;
      end
      if (ev && !bsy) begin
        if (kc <= 9) begin
          if (m_cnt < N) begin
            for (int i = N - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
            m_dig[0] = int'(kc);
            m_cnt++;
          end else m_ovf = 1;
        end else if (kc == 10) begin
          for (int i = 0; i < N; i++) m_dig[i] = 0;
          m_cnt = 0; m_ovf = 0;
        end else if (kc == 11) begin
          if (m_cnt > 0) begin
            for (int i = 0; i < N - 1; i++) m_dig[i] = m_dig[i+1];
            m_dig[N-1] = 0;
            m_cnt--;
          end
        end else if (kc == 12) begin
          m_conv = 0;
          for (int i = N - 1; i >= 0; i--) m_conv = m_conv * 10 + m_dig[i];
          m_timer = N + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [4*N-1:0] ed;
    logic [7*N-1:0] es;
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        ed[4*i +: 4] = 4'(m_dig[i]);
        es[7*i +: 7] = (LZB && i != 0 && i >= m_cnt) ? 7'h7F : glyph(m_dig[i]);
      end
      chk("digits_bcd", 64'(digits_bcd), 64'(ed));
      chk("digit_count", 64'(digit_count), 64'(m_cnt));
      chk("segs", 64'(segs), 64'(es));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("value", 64'(value), 64'(m_val));
      chk("value_valid", 64'(value_valid), 64'(m_timer == 1));
      chk("busy", 64'(busy), 64'(m_timer >= 2));
    end
  end

  task automatic key(input int k, input int hold, input int gap);
    kv = 1'b1; kc = 4'(k);
    repeat (hold) @(negedge clk);
    kv = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1'b1; kv = 1'b0; kc = 4'd0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_digits", 64'(digits_bcd), 64'h0);
    chk("rst_count", 64'(digit_count), 64'h0);
    chk("rst_value", 64'(value), 64'h0);
    chk("rst_busy_vv", 64'({busy, value_valid, overflow}), 64'h0);

    // 1,2,3,4 then enter
    key(1, 2, 2); key(2, 2, 2); key(3, 2, 2); key(4, 2, 2);
    chk("entry_digits", 64'(digits_bcd), 64'h1234);
    chk("entry_count", 64'(digit_count), 64'd4);
    kv = 1'b1; kc = 4'hC;
    n = 0; seen = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (value_valid) begin n = i; seen = 1; break; end
    end
    chk("vv_latency", 64'(n), 64'd5);
    chk("conv_value", 64'(value), 64'd1234);
    chk("entry_kept", 64'(digits_bcd), 64'h1234);
    kv = 1'b0; repeat (2) @(negedge clk);

    // overflow and clear
    key(10, 2, 2);
    repeat (5) key(9, 2, 2);
    chk("ovf_digits", 64'(digits_bcd), 64'h9999);
    chk("ovf_flag", 64'(overflow), 64'd1);
    key(10, 2, 2);
    chk("clr_all", 64'({digits_bcd, digit_count, overflow}), 64'h0);
    chk("clr_value_kept", 64'(value), 64'd1234);

    // backspace
    key(5, 2, 2); key(6, 2, 2); key(11, 2, 2);
    chk("bksp_digits", 64'(digits_bcd), 64'h0005);
    chk("bksp_count", 64'(digit_count), 64'd1);
    key(11, 2, 2); key(11, 2, 2);
    chk("bksp_floor", 64'({digits_bcd, digit_count}), 64'h0);

    // long hold yields one digit
    key(7, 20, 2);
    chk("hold_digits", 64'(digits_bcd), 64'h0007);
    chk("hold_count", 64'(digit_count), 64'd1);

    // display of 0042
    key(10, 2, 2); key(4, 2, 2); key(2, 2, 2);
    if (LZB) chk("segs_0042", 64'(segs), 64'({7'h7F, 7'h7F, 7'h19, 7'h24}));
    else     chk("segs_0042", 64'(segs), 64'({7'h40, 7'h40, 7'h19, 7'h24}));

    // enter, key 3 during busy, reset in 2nd CONV cycle with key held across it
    kv = 1'b1; kc = 4'hC;
    @(negedge clk);
    chk("busy_conv1", 64'(busy), 64'd1);
    kv = 1'b0;
    @(negedge clk);
    kv = 1'b1; kc = 4'd3; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (value_valid) seen = 1;
    end
    chk("abort_no_vv", 64'(seen), 64'd0);
    chk("abort_state", 64'({digits_bcd, digit_count, overflow, busy}), 64'h0);
    chk("abort_value", 64'(value), 64'd0);
    kv = 1'b0; repeat (2) @(negedge clk);

    // randomized traffic
    repeat (4000) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) kv = ~kv;
      if ($urandom_range(0, 9) < 7) kc = 4'($urandom_range(0, 9));
      else                          kc = 4'($urandom_range(10, 15));
      @(negedge clk);
    end
    rst = 1'b0; kv = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
